// File: rtl/execute_mem_bco_redirect_pkg.sv
// Shared definitions for the memory-stage branch-override redirect slice:
// widths, entry-table geometry, branch age arithmetic and small helpers.
package execute_mem_pkg;

    localparam int BID_W     = 4;
    localparam int PC_W      = 32;
    localparam int FT_OFFSET = 8;
    localparam int IDX_W     = BID_W - 1;
    localparam int N_ENT     = 2 ** IDX_W;

    typedef struct packed {
        logic [BID_W-1:0] bid;
        logic [PC_W-1:0]  pc;
    } redirect_t;

    // Distance of a branch from the head; smaller means older. Wraps mod 2^BID_W.
    function automatic logic [BID_W-1:0] bid_age(input logic [BID_W-1:0] b,
                                                 input logic [BID_W-1:0] head);
        return b - head;
    endfunction

    // Number of set bits in an entry mask.
    function automatic logic [IDX_W:0] count_ones(input logic [N_ENT-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < N_ENT; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/execute_mem_bco_redirect_if.sv
// Override stream, age/commit/flush controls and the fetch redirect handshake.
// master: the surrounding pipeline (drives overrides, consumes the redirect).
// slave:  the redirect block.
interface execute_mem_bco_redirect_if;
    import execute_mem_pkg::*;

    logic             i_bco_valid;
    logic [BID_W-1:0] i_bco_bid;
    logic [PC_W-1:0]  i_bco_pc;
    logic             i_bco_taken;
    logic [PC_W-1:0]  i_bco_target;
    logic [BID_W-1:0] i_head_bid;
    logic             i_commit_valid;
    logic [BID_W-1:0] i_commit_bid;
    logic             i_flush;
    logic             o_redirect_valid;
    logic [BID_W-1:0] o_redirect_bid;
    logic [PC_W-1:0]  o_redirect_pc;
    logic             i_redirect_ready;

    modport master (
        output i_bco_valid, i_bco_bid, i_bco_pc, i_bco_taken, i_bco_target,
        output i_head_bid, i_commit_valid, i_commit_bid, i_flush, i_redirect_ready,
        input  o_redirect_valid, o_redirect_bid, o_redirect_pc
    );

    modport slave (
        input  i_bco_valid, i_bco_bid, i_bco_pc, i_bco_taken, i_bco_target,
        input  i_head_bid, i_commit_valid, i_commit_bid, i_flush, i_redirect_ready,
        output o_redirect_valid, o_redirect_bid, o_redirect_pc
    );
endinterface

// File: rtl/execute_mem_bco_oldest_sel.sv
// Combinational oldest-valid selector over an age-ordered entry table.
// Age is measured from head; the lowest-age valid entry wins.
module execute_mem_bco_oldest_sel
    import execute_mem_pkg::*;
(
    input  logic [N_ENT-1:0]            valid,
    input  logic [N_ENT-1:0][BID_W-1:0] bids,
    input  logic [BID_W-1:0]            head,
    output logic                        found,
    output logic [IDX_W-1:0]            idx,
    output logic [BID_W-1:0]            bid
);

    logic             found_s;
    logic             take_s;
    logic [IDX_W-1:0] idx_s;
    logic [BID_W-1:0] bid_s;
    logic [BID_W-1:0] best_age_s;

    // Linear scan keeping the youngest-age (oldest) valid entry seen so far.
    always_comb begin
        found_s    = 1'b0;
        take_s     = 1'b0;
        idx_s      = '0;
        bid_s      = '0;
        best_age_s = '1;
        for (int i = 0; i < N_ENT; i++) begin
            take_s     = valid[i] & (~found_s | (bid_age(bids[i], head) < best_age_s));
            found_s    = found_s | take_s;
            idx_s      = take_s ? IDX_W'(i) : idx_s;
            bid_s      = take_s ? bids[i] : bid_s;
            best_age_s = take_s ? bid_age(bids[i], head) : best_age_s;
        end
        found = found_s;
        idx   = idx_s;
        bid   = bid_s;
    end

endmodule

// File: rtl/execute_mem_bco_redirect.sv
// Buffers branch overrides per branch ID, issues the oldest as a fetch redirect,
// lets an older override preempt a pending one, and squashes younger overrides
// once a redirect is accepted.
// Optional statistics counters: define EXECUTE_MEM_BCO_REDIRECT_STAT_EN.
module execute_mem_bco_redirect
    import execute_mem_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    execute_mem_bco_redirect_if.slave bus
`ifdef EXECUTE_MEM_BCO_REDIRECT_STAT_EN
    ,
    output logic [31:0]               o_stat_redirects,
    output logic [31:0]               o_stat_squashed
`endif
);

    logic [N_ENT-1:0]            ent_valid_r;
    logic [N_ENT-1:0][BID_W-1:0] ent_bid_r;
    logic [N_ENT-1:0][PC_W-1:0]  ent_pc_r;
    logic [N_ENT-1:0]            ent_valid_nx_s;
    logic [N_ENT-1:0]            squash_mask_s;

    logic                        out_valid_r;
    redirect_t                   out_r;

    logic                        found_s;
    logic [IDX_W-1:0]            sel_idx_s;
    logic [BID_W-1:0]            sel_bid_s;

    logic [BID_W-1:0]            out_age_s;
    logic [BID_W-1:0]            sel_age_s;
    logic [BID_W-1:0]            bco_age_s;
    logic                        accept_s;
    logic                        preempt_s;
    logic                        load_s;
    logic                        bco_drop_s;
    logic                        bco_cap_s;
    logic [IDX_W-1:0]            cap_idx_s;
    logic [PC_W-1:0]             bco_pc_s;

    execute_mem_bco_oldest_sel u_oldest_sel (
        .valid (ent_valid_r),
        .bids  (ent_bid_r),
        .head  (bus.i_head_bid),
        .found (found_s),
        .idx   (sel_idx_s),
        .bid   (sel_bid_s)
    );

    assign out_age_s  = bid_age(out_r.bid, bus.i_head_bid);
    assign sel_age_s  = bid_age(sel_bid_s, bus.i_head_bid);
    assign bco_age_s  = bid_age(bus.i_bco_bid, bus.i_head_bid);
    assign accept_s   = out_valid_r & bus.i_redirect_ready;
    // A completing handshake takes priority over preemption.
    assign preempt_s  = out_valid_r & ~accept_s & found_s & (sel_age_s < out_age_s);
    assign load_s     = (~out_valid_r & found_s) | preempt_s;
    assign bco_drop_s = bus.i_bco_valid & accept_s & (bco_age_s > out_age_s);
    assign bco_cap_s  = bus.i_bco_valid & ~bco_drop_s;
    assign cap_idx_s  = bus.i_bco_bid[IDX_W-1:0];
    assign bco_pc_s   = bus.i_bco_taken ? bus.i_bco_target
                                        : bus.i_bco_pc + PC_W'(FT_OFFSET);

    // Next entry valids: clear on load, commit or accept-squash; a capture overrides all.
    always_comb begin
        ent_valid_nx_s = '0;
        squash_mask_s  = '0;
        for (int i = 0; i < N_ENT; i++) begin
            squash_mask_s[i]  = accept_s & ent_valid_r[i]
                              & (bid_age(ent_bid_r[i], bus.i_head_bid) > out_age_s);
            ent_valid_nx_s[i] = (bco_cap_s & (cap_idx_s == IDX_W'(i)))
                              | (ent_valid_r[i]
                                 & ~squash_mask_s[i]
                                 & ~(bus.i_commit_valid & (ent_bid_r[i] == bus.i_commit_bid))
                                 & ~(load_s & (sel_idx_s == IDX_W'(i))));
        end
    end

    // Entry table state; flush drops every buffered override including a same-cycle capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid_r <= '0;
            ent_bid_r   <= '0;
            ent_pc_r    <= '0;
        end else if (bus.i_flush) begin
            ent_valid_r <= '0;
        end else begin
            ent_valid_r <= ent_valid_nx_s;
            if (bco_cap_s) begin
                ent_bid_r[cap_idx_s] <= bus.i_bco_bid;
                ent_pc_r[cap_idx_s]  <= bco_pc_s;
            end
        end
    end

    // Redirect output register: hold until accepted, reload when idle or preempted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else if (bus.i_flush || accept_s) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_r.bid   <= sel_bid_s;
            out_r.pc    <= ent_pc_r[sel_idx_s];
        end
    end

    assign bus.o_redirect_valid = out_valid_r;
    assign bus.o_redirect_bid   = out_r.bid;
    assign bus.o_redirect_pc    = out_r.pc;

`ifdef EXECUTE_MEM_BCO_REDIRECT_STAT_EN
    logic [31:0] stat_red_r;
    logic [31:0] stat_sq_r;
    logic [31:0] sq_inc_s;

    assign sq_inc_s = 32'(count_ones(squash_mask_s)) + {31'd0, bco_drop_s} + {31'd0, preempt_s};

    // Saturating event counters; deliberately unaffected by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_red_r <= 32'd0;
            stat_sq_r  <= 32'd0;
        end else begin
            stat_red_r <= sat_add32(stat_red_r, {31'd0, accept_s});
            stat_sq_r  <= bus.i_flush ? stat_sq_r : sat_add32(stat_sq_r, sq_inc_s);
        end
    end

    assign o_stat_redirects = stat_red_r;
    assign o_stat_squashed  = stat_sq_r;
`endif

endmodule

// File: tb/tb_execute_mem_bco_redirect.sv
// Directed self-checking bench for execute_mem_bco_redirect.
module tb_execute_mem_bco_redirect;
    import execute_mem_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    execute_mem_bco_redirect_if bus ();

`ifdef EXECUTE_MEM_BCO_REDIRECT_STAT_EN
    logic [31:0] stat_redirects;
    logic [31:0] stat_squashed;
`endif

    execute_mem_bco_redirect dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus.slave)
`ifdef EXECUTE_MEM_BCO_REDIRECT_STAT_EN
        ,
        .o_stat_redirects (stat_redirects),
        .o_stat_squashed  (stat_squashed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bco(input logic [3:0] bid, input logic [31:0] pc,
                       input logic taken, input logic [31:0] target);
        bus.i_bco_valid  = 1'b1;
        bus.i_bco_bid    = bid;
        bus.i_bco_pc     = pc;
        bus.i_bco_taken  = taken;
        bus.i_bco_target = target;
    endtask

    task automatic bco_idle();
        bus.i_bco_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.i_bco_valid = 1'b0;
        bus.i_bco_bid = 4'd0;
        bus.i_bco_pc = 32'd0;
        bus.i_bco_taken = 1'b0;
        bus.i_bco_target = 32'd0;
        bus.i_head_bid = 4'd0;
        bus.i_commit_valid = 1'b0;
        bus.i_commit_bid = 4'd0;
        bus.i_flush = 1'b0;
        bus.i_redirect_ready = 1'b0;
        step();
        step();
        check("rst_valid", {31'd0, bus.o_redirect_valid}, 32'd0);
        check("rst_bid", {28'd0, bus.o_redirect_bid}, 32'd0);
        check("rst_pc", bus.o_redirect_pc, 32'd0);
        reset = 1'b0;
        step();

        // Single not-taken override, ready held high.
        bus.i_redirect_ready = 1'b1;
        bco(4'd3, 32'h0000_1000, 1'b0, 32'hDEAD_0000);
        step();
        bco_idle();
        check("t1_not_yet", {31'd0, bus.o_redirect_valid}, 32'd0);
        step();
        check("t1_valid", {31'd0, bus.o_redirect_valid}, 32'd1);
        check("t1_bid", {28'd0, bus.o_redirect_bid}, 32'd3);
        check("t1_pc", bus.o_redirect_pc, 32'h0000_1008);
        step();
        check("t1_idle", {31'd0, bus.o_redirect_valid}, 32'd0);

        // Fall-through add wraps at the top of the address space.
        bco(4'd1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        step();
        bco_idle();
        step();
        check("wrap_valid", {31'd0, bus.o_redirect_valid}, 32'd1);
        check("wrap_pc", bus.o_redirect_pc, 32'h0000_0004);
        step();
        check("wrap_idle", {31'd0, bus.o_redirect_valid}, 32'd0);

        // Taken override held by backpressure for four cycles.
        bus.i_redirect_ready = 1'b0;
        bco(4'd5, 32'h0000_1234, 1'b1, 32'h0000_2000);
        step();
        bco_idle();
        step();
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_valid", {31'd0, bus.o_redirect_valid}, 32'd1);
            check("t2_hold_bid", {28'd0, bus.o_redirect_bid}, 32'd5);
            check("t2_hold_pc", bus.o_redirect_pc, 32'h0000_2000);
            if (i < 3) step();
        end
        bus.i_redirect_ready = 1'b1;
        step();
        check("t2_accepted", {31'd0, bus.o_redirect_valid}, 32'd0);

        // Preemption: 6 issued, then replaced by older 2; accepting 2 leaves nothing.
        bus.i_redirect_ready = 1'b0;
        bco(4'd6, 32'h0000_3000, 1'b0, 32'd0);
        step();
        bco(4'd2, 32'h0000_4000, 1'b0, 32'd0);
        step();
        bco_idle();
        check("t3_first_bid", {28'd0, bus.o_redirect_bid}, 32'd6);
        check("t3_first_pc", bus.o_redirect_pc, 32'h0000_3008);
        step();
        check("t3_pre_valid", {31'd0, bus.o_redirect_valid}, 32'd1);
        check("t3_pre_bid", {28'd0, bus.o_redirect_bid}, 32'd2);
        check("t3_pre_pc", bus.o_redirect_pc, 32'h0000_4008);
        bus.i_redirect_ready = 1'b1;
        step();
        check("t3_acc_idle", {31'd0, bus.o_redirect_valid}, 32'd0);
        step();
        check("t3_no_more_a", {31'd0, bus.o_redirect_valid}, 32'd0);
        step();
        check("t3_no_more_b", {31'd0, bus.o_redirect_valid}, 32'd0);

        // Wrapped ages with head=14: 15 (age 1) beats 1 (age 3); accept squashes 1
        // and drops a same-cycle younger override (bid 0, age 2).
        bus.i_head_bid = 4'd14;
        bus.i_redirect_ready = 1'b0;
        bco(4'd15, 32'h0000_0100, 1'b1, 32'h0000_6000);
        step();
        bco(4'd1, 32'h0000_0200, 1'b1, 32'h0000_5000);
        step();
        bco_idle();
        check("t4_bid", {28'd0, bus.o_redirect_bid}, 32'd15);
        check("t4_pc", bus.o_redirect_pc, 32'h0000_6000);
        step();
        check("t4_no_preempt", {28'd0, bus.o_redirect_bid}, 32'd15);
        bus.i_redirect_ready = 1'b1;
        bco(4'd0, 32'h0000_0300, 1'b0, 32'd0);
        step();
        bco_idle();
        check("t4_acc_idle", {31'd0, bus.o_redirect_valid}, 32'd0);
        step();
        check("t4_squash_a", {31'd0, bus.o_redirect_valid}, 32'd0);
        step();
        check("t4_squash_b", {31'd0, bus.o_redirect_valid}, 32'd0);

        // Commit clears a pending entry: after moving head, bid 4 would
        // otherwise be older than the held bid 2 and preempt it.
        bus.i_head_bid = 4'd0;
        bus.i_redirect_ready = 1'b0;
        bco(4'd2, 32'h0000_7000, 1'b0, 32'd0);
        step();
        bco(4'd4, 32'h0000_7100, 1'b0, 32'd0);
        step();
        bco_idle();
        check("t5_bid", {28'd0, bus.o_redirect_bid}, 32'd2);
        bus.i_commit_valid = 1'b1;
        bus.i_commit_bid = 4'd4;
        step();
        bus.i_commit_valid = 1'b0;
        bus.i_head_bid = 4'd3;
        step();
        check("t5_commit_a", {28'd0, bus.o_redirect_bid}, 32'd2);
        step();
        check("t5_commit_b", {28'd0, bus.o_redirect_bid}, 32'd2);
        check("t5_commit_pc", bus.o_redirect_pc, 32'h0000_7008);
        bus.i_redirect_ready = 1'b1;
        step();
        check("t5_acc_idle", {31'd0, bus.o_redirect_valid}, 32'd0);
        bus.i_head_bid = 4'd0;
        step();
        check("t5_nothing", {31'd0, bus.o_redirect_valid}, 32'd0);

        // Flush coinciding with a capture wins.
        bco(4'd7, 32'h0000_9000, 1'b0, 32'd0);
        bus.i_flush = 1'b1;
        step();
        bco_idle();
        bus.i_flush = 1'b0;
        step();
        check("t6_flush_a", {31'd0, bus.o_redirect_valid}, 32'd0);
        step();
        check("t6_flush_b", {31'd0, bus.o_redirect_valid}, 32'd0);

        // Reset mid-handshake drops the pending redirect.
        bus.i_redirect_ready = 1'b0;
        bco(4'd3, 32'h0000_8000, 1'b0, 32'd0);
        step();
        bco_idle();
        step();
        check("t7_pending", {31'd0, bus.o_redirect_valid}, 32'd1);
        check("t7_pending_pc", bus.o_redirect_pc, 32'h0000_8008);
        reset = 1'b1;
        step();
        check("t7_rst_valid", {31'd0, bus.o_redirect_valid}, 32'd0);
        check("t7_rst_bid", {28'd0, bus.o_redirect_bid}, 32'd0);
        check("t7_rst_pc", bus.o_redirect_pc, 32'd0);
`ifdef EXECUTE_MEM_BCO_REDIRECT_STAT_EN
        check("t7_stat_red", stat_redirects, 32'd0);
        check("t7_stat_sq", stat_squashed, 32'd0);
`endif
        reset = 1'b0;
        step();
        check("t7_after", {31'd0, bus.o_redirect_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
